// File: rtl/daq_pkg.sv
// rtl/daq_pkg.sv - shared widths, word layout and keep helpers for the pixel capture path
package daq_pkg;
   localparam int DATA_W         = 8;
   localparam int WORD_W         = 32;
   localparam int BYTES_PER_WORD = 4;
   localparam int KEEP_W         = BYTES_PER_WORD;
   localparam int ENTRY_W        = WORD_W + KEEP_W + 2;
   localparam int FLAG_SOF       = WORD_W + KEEP_W;
   localparam int FLAG_EOL       = WORD_W + KEEP_W + 1;

   typedef struct packed {
      logic              eol;
      logic              sof;
      logic [KEEP_W-1:0] keep;
      logic [WORD_W-1:0] data;
   } daq_word_t;

   // byte count 0 stands for a completely filled word
   function automatic logic [KEEP_W-1:0] keep_for_bytes(input logic [1:0] filled);
      case (filled)
         2'd1:    keep_for_bytes = 4'h1;
         2'd2:    keep_for_bytes = 4'h3;
         2'd3:    keep_for_bytes = 4'h7;
         default: keep_for_bytes = 4'hF;
      endcase
   endfunction

   function automatic logic [WORD_W-1:0] keep_mask(input logic [KEEP_W-1:0] keep);
      keep_mask = {{8{keep[3]}}, {8{keep[2]}}, {8{keep[1]}}, {8{keep[0]}}};
   endfunction
endpackage

// File: rtl/daq_word_fifo.sv
// rtl/daq_word_fifo.sv - synchronous word FIFO with registered head-of-queue output
module daq_word_fifo
   import daq_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic [ENTRY_W-1:0] push_data,
   input  logic               pop,
   output logic [ENTRY_W-1:0] dout,
   output logic               full,
   output logic               empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [AW:0]        count;
   logic               do_push, do_pop, load_push;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   // the pushed word becomes the head when nothing older will remain
   assign load_push = do_push & (do_pop ? (count == CNT_ONE) : empty);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         count <= count + (do_push ? CNT_ONE : '0) - (do_pop ? CNT_ONE : '0);
         if (load_push)
            dout <= push_data;
         else if (do_pop)
            dout <= mem[rd_ptr + PTR_ONE];
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/daq_pixel_capture.sv
// rtl/daq_pixel_capture.sv - sensor bus capture, 32-bit word packing, frame statistics and error flags
module daq_pixel_capture
   import daq_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int LINE_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic [7:0]        data_in,
   input  logic              pix_clk_in,
   input  logic              frame_vaild_in,
   input  logic              line_vaild_in,
   output logic [31:0]       m_data,
   output logic [3:0]        m_keep,
   output logic              m_sof,
   output logic              m_eol,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              frame_done,
   output logic [LINE_W-1:0] frame_lines,
   output logic [LINE_W-1:0] line_pixels,
   output logic [15:0]       frame_cnt,
   output logic              ovf_err,
   output logic              len_err
);
   localparam logic [LINE_W-1:0] L_ONE = 1;

   logic [SYNC_STAGES-1:0][DATA_W-1:0] data_sync;
   logic [SYNC_STAGES-1:0] pix_sync, fv_sync, lv_sync;
   logic [SYNC_STAGES:0]   settle;
   logic                   pix_d, fv_d, line_d;
   logic [DATA_W-1:0]      data_s;
   logic                   pix_s, fv_s, line_s, settled;
   logic                   pix_rise, fv_rise, fv_fall, line_end, capture, has_px;
   logic                   armed;
   logic [1:0]             byte_idx;
   logic [23:0]            pack_data;
   logic                   hold_valid, hold_sof, sof_pending;
   logic [WORD_W-1:0]      hold_data;
   logic [KEEP_W-1:0]      part_keep;
   logic                   push_en;
   daq_word_t              push_word, head;
   logic                   fifo_full, fifo_empty, fifo_pop;
   logic [LINE_W-1:0]      line_px, lines_cnt, first_px, last_px;

   assign data_s  = data_sync[SYNC_STAGES-1];
   assign pix_s   = pix_sync[SYNC_STAGES-1];
   assign fv_s    = fv_sync[SYNC_STAGES-1];
   assign line_s  = fv_s & lv_sync[SYNC_STAGES-1];
   // edges are ignored until the chains hold real samples, so reset mid-frame never looks like a frame start
   assign settled  = settle[SYNC_STAGES];
   assign pix_rise = settled & pix_s & ~pix_d;
   assign fv_rise  = settled & fv_s & ~fv_d;
   assign fv_fall  = armed & fv_d & ~fv_s;
   assign line_end = armed & line_d & ~line_s;
   assign capture  = armed & line_s & pix_rise;
   assign has_px   = (line_px != '0);
   assign part_keep = keep_for_bytes(byte_idx);

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         data_sync <= '0;
         pix_sync  <= '0;
         fv_sync   <= '0;
         lv_sync   <= '0;
         settle    <= '0;
         pix_d     <= 1'b0;
         fv_d      <= 1'b0;
         line_d    <= 1'b0;
      end else begin
         data_sync <= {data_sync[SYNC_STAGES-2:0], data_in};
         pix_sync  <= {pix_sync[SYNC_STAGES-2:0], pix_clk_in};
         fv_sync   <= {fv_sync[SYNC_STAGES-2:0], frame_vaild_in};
         lv_sync   <= {lv_sync[SYNC_STAGES-2:0], line_vaild_in};
         settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
         pix_d     <= pix_s;
         fv_d      <= fv_s;
         line_d    <= line_s;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         armed       <= 1'b0;
         byte_idx    <= 2'd0;
         pack_data   <= '0;
         hold_valid  <= 1'b0;
         hold_sof    <= 1'b0;
         hold_data   <= '0;
         sof_pending <= 1'b0;
         push_en     <= 1'b0;
         push_word   <= '0;
         line_px     <= '0;
         lines_cnt   <= '0;
         first_px    <= '0;
         last_px     <= '0;
         frame_done  <= 1'b0;
         frame_lines <= '0;
         line_pixels <= '0;
         frame_cnt   <= '0;
         len_err     <= 1'b0;
      end else begin
         push_en    <= 1'b0;
         frame_done <= 1'b0;
         if (fv_rise) begin
            armed       <= 1'b1;
            sof_pending <= 1'b1;
         end
         // a completed word waits in the hold stage so the line end can still mark it eol
         if (capture) begin
            line_px <= line_px + L_ONE;
            if (hold_valid) begin
               push_en    <= 1'b1;
               push_word  <= '{eol: 1'b0, sof: hold_sof, keep: 4'hF, data: hold_data};
               hold_valid <= 1'b0;
            end
            case (byte_idx)
               2'd0: pack_data[7:0]   <= data_s;
               2'd1: pack_data[15:8]  <= data_s;
               2'd2: pack_data[23:16] <= data_s;
               default: begin
                  hold_data   <= {data_s, pack_data};
                  hold_valid  <= 1'b1;
                  hold_sof    <= sof_pending;
                  sof_pending <= 1'b0;
               end
            endcase
            byte_idx <= byte_idx + 2'd1;
         end
         if (line_end) begin
            if (byte_idx != 2'd0) begin
               push_en     <= 1'b1;
               push_word   <= '{eol: 1'b1, sof: sof_pending, keep: part_keep,
                                data: {8'h00, pack_data} & keep_mask(part_keep)};
               sof_pending <= 1'b0;
               byte_idx    <= 2'd0;
            end else if (hold_valid) begin
               push_en    <= 1'b1;
               push_word  <= '{eol: 1'b1, sof: hold_sof, keep: 4'hF, data: hold_data};
               hold_valid <= 1'b0;
            end
            line_px <= '0;
            if (has_px) begin
               lines_cnt <= lines_cnt + L_ONE;
               last_px   <= line_px;
               if (lines_cnt == '0)
                  first_px <= line_px;
               else if (line_px != first_px)
                  len_err <= 1'b1;
            end
         end
         // a line still open at frame end has just been closed above; fold it into the report
         if (fv_fall) begin
            frame_done  <= 1'b1;
            frame_lines <= (line_end && has_px) ? lines_cnt + L_ONE : lines_cnt;
            line_pixels <= (line_end && has_px) ? line_px : last_px;
            frame_cnt   <= frame_cnt + 16'd1;
            lines_cnt   <= '0;
            last_px     <= '0;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst)
         ovf_err <= 1'b0;
      else if (push_en && fifo_full && !fifo_pop)
         ovf_err <= 1'b1;
   end

   assign fifo_pop = m_valid & m_ready;
   assign m_valid  = ~fifo_empty;
   assign m_data   = head.data;
   assign m_keep   = head.keep;
   assign m_sof    = head.sof;
   assign m_eol    = head.eol;

   daq_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (sys_clk),
      .rst       (rst),
      .push      (push_en),
      .push_data (push_word),
      .pop       (fifo_pop),
      .dout      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );
endmodule

// File: tb/tb_daq_pixel_capture.sv
// tb/tb_daq_pixel_capture.sv - scoreboard bench for daq_pixel_capture
module tb_daq_pixel_capture;
   localparam int HALF = 7;

   logic        sys_clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  data_in = '0;
   logic        pix_clk_in = 1'b0;
   logic        frame_vaild_in = 1'b0;
   logic        line_vaild_in = 1'b0;
   logic [31:0] m_data;
   logic [3:0]  m_keep;
   logic        m_sof, m_eol, m_valid;
   logic        m_ready = 1'b1;
   logic        frame_done;
   logic [15:0] frame_lines, line_pixels, frame_cnt;
   logic        ovf_err, len_err;

   int n_vec = 0;
   int n_err = 0;
   logic [37:0] exp_words[$];
   logic [47:0] exp_frames[$];
   int exp_limit = 1000000;
   bit first_word = 1'b0;
   bit held_ok = 1'b0;
   bit stable_bad = 1'b0;
   logic [37:0] held;

   always #10 sys_clk = ~sys_clk;

   daq_pixel_capture #(.FIFO_DEPTH(8), .LINE_W(16), .SYNC_STAGES(2)) dut (
      .sys_clk(sys_clk), .rst(rst), .data_in(data_in), .pix_clk_in(pix_clk_in),
      .frame_vaild_in(frame_vaild_in), .line_vaild_in(line_vaild_in),
      .m_data(m_data), .m_keep(m_keep), .m_sof(m_sof), .m_eol(m_eol),
      .m_valid(m_valid), .m_ready(m_ready), .frame_done(frame_done),
      .frame_lines(frame_lines), .line_pixels(line_pixels), .frame_cnt(frame_cnt),
      .ovf_err(ovf_err), .len_err(len_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge sys_clk) begin
      if (!rst && m_valid && m_ready) begin
         if (exp_words.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL word: got 0x%0h expected none", {m_eol, m_sof, m_keep, m_data});
         end else begin
            check("word", {m_eol, m_sof, m_keep, m_data}, exp_words.pop_front());
         end
      end
      if (!rst && frame_done) begin
         if (exp_frames.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_done: got lines=%0d px=%0d cnt=%0d expected none",
                     frame_lines, line_pixels, frame_cnt);
         end else begin
            check("frame_stats", {frame_lines, line_pixels, frame_cnt}, exp_frames.pop_front());
         end
      end
      if (m_valid && !m_ready) begin
         if (held_ok && {m_eol, m_sof, m_keep, m_data} !== held) stable_bad = 1'b1;
         held    = {m_eol, m_sof, m_keep, m_data};
         held_ok = 1'b1;
      end else begin
         held_ok = 1'b0;
      end
   end

   task automatic clk_n(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic expect_line(input int n, input logic [7:0] base);
      int nw;
      nw = (n + 3) / 4;
      for (int w = 0; w < nw; w++) begin
         logic [31:0] d;
         logic [3:0]  k;
         logic [7:0]  v;
         int cnt;
         d = '0;
         cnt = (n - 4 * w > 4) ? 4 : n - 4 * w;
         for (int b = 0; b < cnt; b++) begin
            v = base + 8'(4 * w + b);
            d[8*b +: 8] = v;
         end
         k = (cnt == 4) ? 4'hF : 4'((1 << cnt) - 1);
         if (exp_limit > 0) begin
            exp_words.push_back({(w == nw - 1) ? 1'b1 : 1'b0, first_word, k, d});
            exp_limit--;
         end
         first_word = 1'b0;
      end
   endtask

   task automatic send_px(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         data_in = base + 8'(i);
         pix_clk_in = 1'b0;
         clk_n(HALF);
         pix_clk_in = 1'b1;
         clk_n(HALF);
      end
   endtask

   task automatic send_line(input int n, input logic [7:0] base, input bit drop_fv);
      expect_line(n, base);
      line_vaild_in = 1'b1;
      clk_n(HALF);
      send_px(n, base);
      pix_clk_in = 1'b0;
      line_vaild_in = 1'b0;
      if (drop_fv) frame_vaild_in = 1'b0;
      clk_n(HALF);
   endtask

   task automatic start_frame();
      frame_vaild_in = 1'b1;
      first_word = 1'b1;
      clk_n(HALF);
   endtask

   task automatic end_frame(input int lines, input int px, input int cnt);
      exp_frames.push_back({16'(lines), 16'(px), 16'(cnt)});
      frame_vaild_in = 1'b0;
      clk_n(HALF);
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while ((exp_words.size() != 0 || exp_frames.size() != 0) && t < 400) begin
         clk_n(1);
         t++;
      end
      n_vec++;
      if (exp_words.size() != 0 || exp_frames.size() != 0) begin
         n_err++;
         $display("FAIL %s: got %0d words %0d frames outstanding expected 0", name,
                  exp_words.size(), exp_frames.size());
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      clk_n(3);
      rst = 1'b0;
      clk_n(1);
      check("reset_m_valid", m_valid, 0);
      check("reset_m_data", m_data, 0);
      check("reset_frame_cnt", frame_cnt, 0);
      check("reset_frame_lines", frame_lines, 0);
      check("reset_ovf_err", ovf_err, 0);
      check("reset_len_err", len_err, 0);
      clk_n(5);

      // single 8 px line: two full words, eol on the second
      start_frame();
      send_line(8, 8'h01, 1'b0);
      end_frame(1, 8, 1);

      // three 6 px lines: full word then 2-byte partial eol word each line
      start_frame();
      for (int l = 0; l < 3; l++) send_line(6, 8'h10, 1'b0);
      end_frame(3, 6, 2);
      check("len_err_equal_lines", len_err, 0);

      start_frame();
      send_line(8, 8'h20, 1'b0);
      send_line(8, 8'h28, 1'b0);
      check("len_err_before_short", len_err, 0);
      send_line(7, 8'h30, 1'b0);
      check("len_err_after_short", len_err, 1);
      end_frame(3, 7, 3);

      start_frame();
      send_line(8, 8'h40, 1'b0);
      send_line(8, 8'h48, 1'b0);
      end_frame(2, 8, 4);
      check("len_err_sticky", len_err, 1);

      // fv and lv drop together with 2 bytes pending
      start_frame();
      exp_frames.push_back({16'd1, 16'd6, 16'd5});
      send_line(6, 8'h50, 1'b1);
      wait_idle("drain_joint_fall");
      check("ovf_err_clear", ovf_err, 0);

      // consumer stalled for a whole frame: only the first 8 words survive
      m_ready = 1'b0;
      exp_limit = 8;
      start_frame();
      for (int l = 0; l < 4; l++) send_line(40, 8'h60, 1'b0);
      end_frame(4, 40, 6);
      clk_n(4);
      check("ovf_err_set", ovf_err, 1);
      check("stall_m_valid", m_valid, 1);
      m_ready = 1'b1;
      exp_limit = 1000000;
      wait_idle("drain_stall");
      clk_n(4);
      check("stall_empty_after_drain", m_valid, 0);
      check("stall_data_stable", stable_bad, 0);

      // reset mid-line: the rest of this frame must be ignored
      frame_vaild_in = 1'b1;
      clk_n(HALF);
      line_vaild_in = 1'b1;
      clk_n(HALF);
      send_px(3, 8'h90);
      rst = 1'b1;
      clk_n(1);
      rst = 1'b0;
      send_px(5, 8'h93);
      pix_clk_in = 1'b0;
      line_vaild_in = 1'b0;
      clk_n(HALF);
      frame_vaild_in = 1'b0;
      clk_n(HALF * 2);
      check("rst_ovf_err", ovf_err, 0);
      check("rst_len_err", len_err, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_no_words", m_valid, 0);

      start_frame();
      send_line(4, 8'h70, 1'b0);
      end_frame(1, 4, 1);
      wait_idle("drain_final");
      check("final_frame_cnt", frame_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
